// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute and drives
// datapath mux and enable controls, with a memory handshake and a trap state.
module mips_mc_ctrl #(
    parameter int ALUCW    = 3,
    parameter int EN_BNE   = 1,
    parameter int EN_ADDI  = 1,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [ALUCW-1:0] alucontrol,
    output logic             pcen,
    output logic             illegal,
    output logic             mem_timeout,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [ALUCW-1:0] ALU_ADD = ALUCW'(3'b010);
    localparam logic [ALUCW-1:0] ALU_SUB = ALUCW'(3'b110);
    localparam logic [ALUCW-1:0] ALU_AND = ALUCW'(3'b000);
    localparam logic [ALUCW-1:0] ALU_OR  = ALUCW'(3'b001);
    localparam logic [ALUCW-1:0] ALU_SLT = ALUCW'(3'b111);

    // Counter is wide enough to hold WAIT_MAX; WLAST is the count at
    // which one more wait cycle means the access has timed out.
    localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] WSAT  = CW'(WAIT_MAX);
    localparam logic [CW-1:0] WLAST = (WAIT_MAX > 0) ? CW'(WAIT_MAX - 1) : '0;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   wait_cnt;
    logic            ill_q;
    logic            to_q;
    logic            timeout_hit;

    logic            c_mem_req;
    logic            c_iord;
    logic            c_memwrite;
    logic            c_irwrite;
    logic            c_regdst;
    logic            c_memtoreg;
    logic            c_regwrite;
    logic            c_alusrca;
    logic [1:0]      c_alusrcb;
    logic [1:0]      c_pcsrc;
    logic [ALUCW-1:0] c_alu;
    logic            c_pcwrite;
    logic            c_branch;
    logic            c_branchne;
    logic            c_pcen;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    // Next-state and Moore control decode, plus the memory timeout check
    always_comb begin
        next_state  = state;
        c_mem_req   = 1'b0;
        c_iord      = 1'b0;
        c_memwrite  = 1'b0;
        c_irwrite   = 1'b0;
        c_regdst    = 1'b0;
        c_memtoreg  = 1'b0;
        c_regwrite  = 1'b0;
        c_alusrca   = 1'b0;
        c_alusrcb   = 2'b00;
        c_pcsrc     = 2'b00;
        c_alu       = '0;
        c_pcwrite   = 1'b0;
        c_branch    = 1'b0;
        c_branchne  = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            FETCH: begin
                c_mem_req = 1'b1;
                c_alusrcb = 2'b01;
                c_alu     = ALU_ADD;
                c_irwrite = mem_ready;
                c_pcwrite = mem_ready;
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                c_alusrcb = 2'b11;
                c_alu     = ALU_ADD;
                unique case (1'b1)
                    (opcode == OP_LW) || (opcode == OP_SW):
                        next_state = MEMADR;
                    (opcode == OP_RTYPE):
                        next_state = EXEC;
                    (opcode == OP_BEQ):
                        next_state = BRANCH;
                    (opcode == OP_BNE) && (EN_BNE != 0):
                        next_state = BRANCH;
                    (opcode == OP_ADDI) && (EN_ADDI != 0):
                        next_state = ADDIEX;
                    (opcode == OP_J):
                        next_state = JUMP;
                    default:
                        next_state = TRAP;
                endcase
            end
            MEMADR: begin
                c_alusrca  = 1'b1;
                c_alusrcb  = 2'b10;
                c_alu      = ALU_ADD;
                next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                c_mem_req = 1'b1;
                c_iord    = 1'b1;
                if (mem_ready) next_state = MEMWB;
            end
            MEMWB: begin
                c_memtoreg = 1'b1;
                c_regwrite = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                c_mem_req  = 1'b1;
                c_iord     = 1'b1;
                c_memwrite = 1'b1;
                if (mem_ready) next_state = FETCH;
            end
            EXEC: begin
                c_alusrca  = 1'b1;
                next_state = ALUWB;
                unique case (funct)
                    6'b100000: c_alu = ALU_ADD;
                    6'b100010: c_alu = ALU_SUB;
                    6'b100100: c_alu = ALU_AND;
                    6'b100101: c_alu = ALU_OR;
                    6'b101010: c_alu = ALU_SLT;
                    default:   next_state = TRAP;
                endcase
            end
            ALUWB: begin
                c_regdst   = 1'b1;
                c_regwrite = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                c_alusrca  = 1'b1;
                c_alu      = ALU_SUB;
                c_pcsrc    = 2'b01;
                c_branch   = (opcode == OP_BEQ);
                c_branchne = (opcode == OP_BNE) && (EN_BNE != 0);
                next_state = FETCH;
            end
            ADDIEX: begin
                c_alusrca  = 1'b1;
                c_alusrcb  = 2'b10;
                c_alu      = ALU_ADD;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                c_regwrite = 1'b1;
                next_state = FETCH;
            end
            JUMP: begin
                c_pcsrc    = 2'b10;
                c_pcwrite  = 1'b1;
                next_state = FETCH;
            end
            default: begin
                next_state = TRAP;
            end
        endcase
        // The last allowed wait cycle elapsing overrides any other successor.
        if ((WAIT_MAX != 0) && c_mem_req && !mem_ready && (wait_cnt == WLAST)) begin
            timeout_hit = 1'b1;
            next_state  = TRAP;
        end
    end

    // Memory wait counter: restarts with each new state, saturates
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (next_state != state)
            wait_cnt <= '0;
        else if (c_mem_req && !mem_ready && (wait_cnt != WSAT))
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Sticky trap and timeout flags, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ill_q <= 1'b0;
            to_q  <= 1'b0;
        end else begin
            if (next_state == TRAP) ill_q <= 1'b1;
            if (timeout_hit)        to_q  <= 1'b1;
        end
    end

    assign c_pcen = c_pcwrite | (c_branch & zero) | (c_branchne & ~zero);

    // Reset gates every output combinationally so an in-flight access
    // (in particular a store) is withdrawn the moment reset rises.
    assign mem_req     = c_mem_req  & ~reset;
    assign iord        = c_iord     & ~reset;
    assign memwrite    = c_memwrite & ~reset;
    assign irwrite     = c_irwrite  & ~reset;
    assign regdst      = c_regdst   & ~reset;
    assign memtoreg    = c_memtoreg & ~reset;
    assign regwrite    = c_regwrite & ~reset;
    assign alusrca     = c_alusrca  & ~reset;
    assign alusrcb     = reset ? 2'b00 : c_alusrcb;
    assign pcsrc       = reset ? 2'b00 : c_pcsrc;
    assign alucontrol  = reset ? '0 : c_alu;
    assign pcen        = c_pcen     & ~reset;
    assign illegal     = ill_q      & ~reset;
    assign mem_timeout = to_q       & ~reset;
    assign state_o     = reset ? 4'd0 : state;

endmodule
